// File: rtl/demux_1to2_router.sv
// rtl/demux_1to2_router.sv - 1-to-2 routing demux with per-port FIFOs; optional stats via DEMUX_ROUTER_STATS_EN
module demux_router_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] rdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_ptr;
    logic [AW:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // Storage is cleared so the head reads zero until the first write.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr <= wr_ptr + ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == FULL_CNT);
    assign valid = (count != '0);
    assign rdata = mem[rd_ptr[AW-1:0]];
endmodule

module demux_1to2_router #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out0_valid,
    output logic [WIDTH-1:0] out0_data,
    input  logic             out0_ready,
    output logic             out1_valid,
    output logic [WIDTH-1:0] out1_data,
    input  logic             out1_ready
`ifdef DEMUX_ROUTER_STATS_EN
    ,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
`endif
);
    logic full0;
    logic full1;
    logic push0;
    logic push1;
    logic pop0;
    logic pop1;

    // Full is taken from registered occupancy, so a same-cycle pop never frees a slot early.
    assign in_ready = in_sel ? !full1 : !full0;
    assign push0    = in_valid && !in_sel && !full0;
    assign push1    = in_valid &&  in_sel && !full1;
    assign pop0     = out0_valid && out0_ready;
    assign pop1     = out1_valid && out1_ready;

    demux_router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .rst   (rst),
        .push  (push0),
        .wdata (in_data),
        .pop   (pop0),
        .full  (full0),
        .valid (out0_valid),
        .rdata (out0_data)
    );

    demux_router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push1),
        .wdata (in_data),
        .pop   (pop1),
        .full  (full1),
        .valid (out1_valid),
        .rdata (out1_data)
    );

`ifdef DEMUX_ROUTER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (pop0) cnt0 <= cnt0 + 16'd1;
            if (pop1) cnt1 <= cnt1 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_demux_1to2_router.sv
// tb/tb_demux_1to2_router.sv - randomized and directed check of demux_1to2_router against a queue model
module tb_demux_1to2_router;
    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out0_valid;
    logic [WIDTH-1:0] out0_data;
    logic             out0_ready;
    logic             out1_valid;
    logic [WIDTH-1:0] out1_data;
    logic             out1_ready;
`ifdef DEMUX_ROUTER_STATS_EN
    logic [15:0]      cnt0;
    logic [15:0]      cnt1;
`endif

    demux_1to2_router #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_data  (out0_data),
        .out0_ready (out0_ready),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_ready (out1_ready)
`ifdef DEMUX_ROUTER_STATS_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic             wr0;
    logic             wr1;
    logic [15:0]      mcnt0;
    logic [15:0]      mcnt1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: apply inputs, check outputs mid-cycle, then advance the model past the edge.
    task automatic cyc(input logic v, input logic s, input logic [WIDTH-1:0] d,
                       input logic r0, input logic r1);
        logic exp_rdy;
        logic acc;
        logic p0;
        logic p1;
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        @(negedge clk);
        exp_rdy = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
        chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
        if (q0.size() != 0)  chk("out0_data", 32'(out0_data), 32'(q0[0]));
        else if (!wr0)       chk("out0_data_rst", 32'(out0_data), 32'd0);
        if (q1.size() != 0)  chk("out1_data", 32'(out1_data), 32'(q1[0]));
        else if (!wr1)       chk("out1_data_rst", 32'(out1_data), 32'd0);
`ifdef DEMUX_ROUTER_STATS_EN
        chk("cnt0", 32'(cnt0), 32'(mcnt0));
        chk("cnt1", 32'(cnt1), 32'(mcnt1));
`endif
        acc = v && exp_rdy;
        p0  = r0 && (q0.size() != 0);
        p1  = r1 && (q1.size() != 0);
        @(posedge clk);
        #1;
        if (p0) begin void'(q0.pop_front()); mcnt0 = mcnt0 + 16'd1; end
        if (p1) begin void'(q1.pop_front()); mcnt1 = mcnt1 + 16'd1; end
        if (acc && !s) begin q0.push_back(d); wr0 = 1'b1; end
        if (acc &&  s) begin q1.push_back(d); wr1 = 1'b1; end
    endtask

    task automatic do_reset(input logic v, input logic s, input logic r0, input logic r1);
        rst        = 1'b1;
        in_valid   = v;
        in_sel     = s;
        in_data    = 16'hDEAD;
        out0_ready = r0;
        out1_ready = r1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        q1.delete();
        wr0   = 1'b0;
        wr1   = 1'b0;
        mcnt0 = '0;
        mcnt1 = '0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        wr0 = 1'b0; wr1 = 1'b0; mcnt0 = '0; mcnt1 = '0;
        do_reset(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Basic routing
        cyc(1'b1, 1'b0, 16'h1234, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 16'hABCD, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

        // Port-0 backpressure; port 1 still accepts
        cyc(1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h0002, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h0003, 1'b0, 1'b0);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        cyc(1'b1, 1'b1, 16'h00FF, 1'b0, 1'b1);

        // Hold, then drain in order while 0x0003 waits
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0003, 1'b0, 1'b1);
        chk("hold_out0_data", 32'(out0_data), 32'h0001);
        cyc(1'b1, 1'b0, 16'h0003, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 16'h0003, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

        // Simultaneous push and pop on port 1
        cyc(1'b1, 1'b1, 16'h0011, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 16'h0022, 1'b0, 1'b1);
        chk("pp_out1_data", 32'(out1_data), 32'h0022);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

        // Reset with both FIFOs full
        cyc(1'b1, 1'b0, 16'hA001, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'hA002, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 16'hB001, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 16'hB002, 1'b0, 1'b0);
        do_reset(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) == 0)
                do_reset(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            else
                cyc(1'($urandom), 1'($urandom), 16'($urandom),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end

`ifdef DEMUX_ROUTER_STATS_EN
        // Counter wrap over 65537 port-0 deliveries
        do_reset(1'b0, 1'b0, 1'b0, 1'b0);
        begin
            int sent = 0;
            while (sent < 65537 || q0.size() != 0) begin
                cyc(sent < 65537, 1'b0, 16'(sent), 1'b1, 1'b0);
                if (sent < 65537) sent++;
            end
        end
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        chk("wrap_cnt0", 32'(cnt0), 32'h0001);
        chk("wrap_cnt1", 32'(cnt1), 32'h0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
